// File: rtl/lix_reg_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lix_reg_arb_pkg
//  Description : Shared helpers and types for the lix_reg_arb arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package lix_reg_arb_pkg;

    // Ceiling log2 for elaboration-time width derivation.
    function automatic int lix_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Requester-index width; a single requester still gets a 1-bit field.
    function automatic int lix_idw(input int n);
        return (n > 1) ? lix_clog2(n) : 1;
    endfunction

    // Occupancy of the shared holding register.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } lix_state_t;

endpackage : lix_reg_arb_pkg
`default_nettype wire

// File: rtl/lix_reg.sv
`default_nettype none
// ============================================================================
//  Module      : lix_reg
//  Description : W-bit holding register with load strobe, enable and
//                asynchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module lix_reg #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         i_en,
    input  logic         i_vld,
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_z
);

    logic [W-1:0] r_z;

    // Capture the incoming word whenever a qualified load is presented.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_z <= '0;
        end else if (i_en && i_vld) begin
            r_z <= i_x;
        end
    end

    assign o_z = r_z;

endmodule : lix_reg
`default_nettype wire

// File: rtl/lix_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : lix_rr_pick
//  Description : Combinational round-robin picker. Searches the request
//                vector starting at the pointer and wrapping around.
//  Revision    : 1.0 - initial release
// ============================================================================
module lix_rr_pick
    import lix_reg_arb_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = lix_idw(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_gnt,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);

    // First requester at or after the pointer, in wrap-around order, wins.
    always_comb begin
        int w_k;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_k   = 0;
        for (int i = 0; i < N; i++) begin
            w_k = int'(i_ptr) + i;
            if (w_k >= N) begin
                w_k = w_k - N;
            end
            if (!o_any && i_req[w_k]) begin
                o_gnt[w_k] = 1'b1;
                o_idx      = IDW'(w_k);
                o_any      = 1'b1;
            end
        end
    end

endmodule : lix_rr_pick
`default_nettype wire

// File: rtl/lix_reg_arb.sv
`default_nettype none
// ============================================================================
//  Module      : lix_reg_arb
//  Description : Round-robin arbiter feeding one shared holding register,
//                presented downstream through a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module lix_reg_arb
    import lix_reg_arb_pkg::*;
#(
    parameter  int W   = 32,
    parameter  int N   = 4,
    localparam int IDW = lix_idw(N)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N-1:0]   i_vld,
    input  logic [N*W-1:0] i_x,
    output logic [N-1:0]   o_rdy,
    output logic           o_vld,
    output logic [W-1:0]   o_z,
    output logic [IDW-1:0] o_id,
    input  logic           i_rdy
);

    lix_state_t     r_state;
    lix_state_t     w_state_nxt;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic [N-1:0]   w_gnt;
    logic [IDW-1:0] w_idx;
    logic           w_any;
    logic           w_acc;
    logic           w_grant;
    logic [W-1:0]   w_x_sel;

    lix_rr_pick #(
        .N (N)
    ) u_pick (
        .i_req (i_vld),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // A slot may load when empty or when its current word is draining now;
    // grants are suppressed while reset is held.
    assign w_acc   = (r_state == ST_EMPTY) || i_rdy;
    assign w_grant = w_acc && w_any && !rst_i;
    assign o_rdy   = w_grant ? w_gnt : '0;
    assign w_x_sel = i_x[int'(w_idx)*W +: W];

    lix_reg #(
        .W (W)
    ) u_lix_reg (
        .clk_i  (clk_i),
        .rst_ni (~rst_i),
        .i_en   (1'b1),
        .i_vld  (w_grant),
        .i_x    (w_x_sel),
        .o_z    (o_z)
    );

    // Occupancy state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Load takes priority over drain so a simultaneous swap keeps the slot full.
    always_comb begin
        w_state_nxt = r_state;
        if (w_grant) begin
            w_state_nxt = ST_FULL;
        end else if ((r_state == ST_FULL) && i_rdy) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // Record the winner and advance the pointer past it on every grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_id  <= '0;
            r_ptr <= '0;
        end else if (w_grant) begin
            r_id  <= w_idx;
            r_ptr <= (int'(w_idx) == N-1) ? '0 : w_idx + IDW'(1);
        end
    end

    assign o_vld = (r_state == ST_FULL);
    assign o_id  = r_id;

endmodule : lix_reg_arb
`default_nettype wire

// File: tb/tb_lix_reg_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lix_reg_arb
//  Description : Directed self-checking bench for lix_reg_arb (N=4/W=32 and
//                N=1/W=8 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lix_reg_arb;

    logic         clk;
    logic         rst_i;
    logic [3:0]   vld;
    logic [127:0] x;
    logic [3:0]   rdy_o;
    logic         ovld;
    logic [31:0]  oz;
    logic [1:0]   oid;
    logic         irdy;

    logic         vld1;
    logic [7:0]   x1;
    logic [0:0]   rdy1_o;
    logic         ovld1;
    logic [7:0]   oz1;
    logic [0:0]   oid1;
    logic         irdy1;

    int n_pass;
    int n_total;

    lix_reg_arb #(.W(32), .N(4)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .i_vld (vld),
        .i_x   (x),
        .o_rdy (rdy_o),
        .o_vld (ovld),
        .o_z   (oz),
        .o_id  (oid),
        .i_rdy (irdy)
    );

    lix_reg_arb #(.W(8), .N(1)) dut1 (
        .clk_i (clk),
        .rst_i (rst_i),
        .i_vld (vld1),
        .i_x   (x1),
        .o_rdy (rdy1_o),
        .o_vld (ovld1),
        .o_z   (oz1),
        .o_id  (oid1),
        .i_rdy (irdy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        vld   = '0;
        x     = '0;
        irdy  = 1'b0;
        vld1  = 1'b0;
        x1    = '0;
        irdy1 = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        vld   = 4'b1111;
        irdy  = 1'b1;
        tick();
        n_total++;
        if (rdy_o !== 4'b0000) $display("FAIL reset_rdy: got %b want 0000", rdy_o);
        else n_pass++;
        n_total++;
        if (ovld !== 1'b0 || oz !== 32'h0 || oid !== 2'd0)
            $display("FAIL reset_state: got vld=%b z=%h id=%0d want 0/0/0", ovld, oz, oid);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_reset_mid();
        do_reset();
        vld = 4'b0100;
        x[2*32 +: 32] = 32'hA5A5_0001;
        x[1*32 +: 32] = 32'h1111_1111;
        irdy = 1'b0;
        #1;
        n_total++;
        if (rdy_o !== 4'b0100) $display("FAIL mid_grant2: got %b want 0100", rdy_o);
        else n_pass++;
        tick();
        n_total++;
        if (ovld !== 1'b1 || oz !== 32'hA5A5_0001 || oid !== 2'd2)
            $display("FAIL mid_load: got vld=%b z=%h id=%0d want 1/a5a50001/2", ovld, oz, oid);
        else n_pass++;
        rst_i = 1'b1;
        #1;
        n_total++;
        if (ovld !== 1'b0 || oz !== 32'h0 || oid !== 2'd0 || rdy_o !== 4'b0000)
            $display("FAIL mid_async_rst: got vld=%b z=%h id=%0d rdy=%b want 0/0/0/0000",
                     ovld, oz, oid, rdy_o);
        else n_pass++;
        rst_i = 1'b0;
        vld   = 4'b1110;
        #1;
        n_total++;
        if (rdy_o !== 4'b0010) $display("FAIL mid_ptr_reset: got %b want 0010", rdy_o);
        else n_pass++;
        tick();
        n_total++;
        if (oid !== 2'd1 || oz !== 32'h1111_1111)
            $display("FAIL mid_after: got id=%0d z=%h want 1/11111111", oid, oz);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_z;
        logic [3:0]  exp_rdy;
        do_reset();
        irdy = 1'b1;
        vld  = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 4; k++) x[k*32 +: 32] = 32'h5000_0000 + c*256 + k;
            exp_rdy = 4'b0001 << (c % 4);
            exp_z   = 32'h5000_0000 + c*256 + (c % 4);
            #1;
            n_total++;
            if (rdy_o !== exp_rdy) $display("FAIL rr_rdy c=%0d: got %b want %b", c, rdy_o, exp_rdy);
            else n_pass++;
            tick();
            n_total++;
            if (ovld !== 1'b1 || oid !== 2'(c % 4) || oz !== exp_z)
                $display("FAIL rr_out c=%0d: got vld=%b id=%0d z=%h want 1/%0d/%h",
                         c, ovld, oid, oz, c % 4, exp_z);
            else n_pass++;
        end
    endtask

    task automatic test_sparse();
        logic [1:0] exp_id [4];
        exp_id = '{2'd1, 2'd3, 2'd1, 2'd3};
        do_reset();
        irdy = 1'b1;
        vld  = 4'b1010;
        for (int k = 0; k < 4; k++) x[k*32 +: 32] = 32'hBEEF_0000 + k;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_total++;
            if (rdy_o !== (4'b0001 << exp_id[c]))
                $display("FAIL sparse_rdy c=%0d: got %b want id %0d", c, rdy_o, exp_id[c]);
            else n_pass++;
            tick();
            n_total++;
            if (oid !== exp_id[c] || oz !== 32'hBEEF_0000 + exp_id[c])
                $display("FAIL sparse_out c=%0d: got id=%0d z=%h want %0d", c, oid, oz, exp_id[c]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        vld  = 4'b1111;
        irdy = 1'b1;
        for (int k = 0; k < 4; k++) x[k*32 +: 32] = 32'hCAFE_0000 + k;
        tick();
        irdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 4; k++) x[k*32 +: 32] = 32'hD000_0000 + c*16 + k;
            #1;
            n_total++;
            if (rdy_o !== 4'b0000) $display("FAIL bp_rdy c=%0d: got %b want 0000", c, rdy_o);
            else n_pass++;
            tick();
            n_total++;
            if (ovld !== 1'b1 || oz !== 32'hCAFE_0000 || oid !== 2'd0)
                $display("FAIL bp_hold c=%0d: got vld=%b z=%h id=%0d want 1/cafe0000/0",
                         c, ovld, oz, oid);
            else n_pass++;
        end
        irdy = 1'b1;
        #1;
        n_total++;
        if (rdy_o !== 4'b0010) $display("FAIL bp_resume: got %b want 0010", rdy_o);
        else n_pass++;
        tick();
        n_total++;
        if (ovld !== 1'b1 || oid !== 2'd1 || oz !== 32'hD000_0041)
            $display("FAIL bp_load: got vld=%b id=%0d z=%h want 1/1/d0000041", ovld, oid, oz);
        else n_pass++;
    endtask

    task automatic test_drain();
        vld  = 4'b0000;
        irdy = 1'b1;
        #1;
        n_total++;
        if (rdy_o !== 4'b0000) $display("FAIL drain_rdy: got %b want 0000", rdy_o);
        else n_pass++;
        tick();
        n_total++;
        if (ovld !== 1'b0 || oz !== 32'hD000_0041 || oid !== 2'd1)
            $display("FAIL drain_out: got vld=%b z=%h id=%0d want 0/d0000041/1", ovld, oz, oid);
        else n_pass++;
        tick();
        n_total++;
        if (ovld !== 1'b0) $display("FAIL drain_stay: got vld=%b want 0", ovld);
        else n_pass++;
        vld  = 4'b1111;
        irdy = 1'b0;
        #1;
        n_total++;
        if (rdy_o !== 4'b0100) $display("FAIL drain_ptr: got %b want 0100", rdy_o);
        else n_pass++;
        tick();
        vld = 4'b0000;
    endtask

    task automatic test_n1();
        logic [7:0] pat;
        logic       full_m;
        logic       exp_rdy;
        logic [7:0] last;
        pat    = 8'b1011_0100;
        full_m = 1'b0;
        last   = 8'h00;
        do_reset();
        vld1 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            x1    = 8'h3C + 8'(c);
            irdy1 = pat[c];
            #1;
            exp_rdy = !full_m || pat[c];
            n_total++;
            if (rdy1_o[0] !== exp_rdy)
                $display("FAIL n1_rdy c=%0d: got %b want %b", c, rdy1_o[0], exp_rdy);
            else n_pass++;
            if (exp_rdy) begin
                last   = x1;
                full_m = 1'b1;
            end else if (full_m && pat[c]) begin
                full_m = 1'b0;
            end
            tick();
            n_total++;
            if (ovld1 !== full_m || oz1 !== last || oid1 !== 1'b0)
                $display("FAIL n1_out c=%0d: got vld=%b z=%h id=%b want %b/%h/0",
                         c, ovld1, oz1, oid1, full_m, last);
            else n_pass++;
        end
        vld1 = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_i   = 1'b1;
        vld     = '0;
        x       = '0;
        irdy    = 1'b0;
        vld1    = 1'b0;
        x1      = '0;
        irdy1   = 1'b0;
        #2;
        test_reset();
        test_reset_mid();
        test_round_robin();
        test_sparse();
        test_backpressure();
        test_drain();
        test_n1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_lix_reg_arb
`default_nettype wire

// File: doc/lix_reg_arb.md
Name: lix_reg_arb

Overview:
- Round-robin arbiter and sequencer for one shared W-bit holding register (lix_reg) between N requesters.
- Each cycle it selects at most one valid requester and loads that requester's data into the register.
- It presents the stored word downstream with a valid/ready handshake.
- Sits in front of A2B pipeline stages where several share-producers feed one register slot.

Parameters:
- W, 32, data width of each requester word and of the stored word.
- N, 4, number of requesters (N >= 1).
- IDW, (N>1 ? clog2(N) : 1), width of the requester-index field. Derived; not overridden.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- i_vld  input  N  per-requester valid; bit k belongs to requester k.
- i_x  input  N*W  requester data; requester k occupies bits [k*W +: W].
- o_rdy  output  N  per-requester grant; one-hot or zero; a transfer occurs when i_vld[k] && o_rdy[k].
- o_vld  output  1  stored word is valid.
- o_z  output  W  stored word.
- o_id  output  IDW  index of the requester whose word is stored.
- i_rdy  input  1  downstream ready; the word is consumed when o_vld && i_rdy.

Behaviour:
- Reset (rst_i=1, any time, asynchronous):
  - o_vld=0, o_z=0, o_id=0, round-robin pointer ptr=0.
  - o_rdy=0 while rst_i is high.
  - A stored word is discarded; there is no partial transfer.
- State is a single flag, full: EMPTY (o_vld=0) or FULL (o_vld=1).
- Accept condition: acc = ~full | i_rdy. An empty slot, or a full slot being drained this cycle, may load.
- Arbitration is combinational within the same cycle:
  - Winner = the first k with i_vld[k]=1, searching k = ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - o_rdy[winner] = acc & |i_vld; all other o_rdy bits are 0.
  - o_rdy never asserts for a requester whose i_vld is 0.
- On a grant (acc & |i_vld), at the next edge:
  - o_z <= i_x[winner]; o_id <= winner; full <= 1.
  - ptr <= (winner+1) mod N.
- Consume without a grant (full & i_rdy & ~|i_vld): full <= 0. o_z and o_id hold their last values.
- Simultaneous consume and grant: the old word leaves and the new word loads in the same edge, so o_vld stays 1. This gives full throughput of 1 word per cycle.
- Full and i_rdy=0: all o_rdy are 0; o_z, o_id and o_vld hold; ptr holds.
- Latency: 1 cycle from grant to o_vld/o_z.
- No requests: ptr holds and nothing is loaded.
- N=1: ptr is constant 0; the block degenerates to a 1-entry buffer with o_rdy[0] = acc.
- Requester contract: i_vld[k] may deassert while not granted; i_x[k] is sampled only in the grant cycle.
- Register load enable drives lix_reg: i_vld = grant, i_en = 1, rst_ni = ~rst_i. o_id, full and ptr are local flops with asynchronous active-high reset.

Decomposition:
- Shared constants/header: clog2 function; IDW derivation.
- Sub-module lix_rr_pick (N):
  - inputs: request vector, ptr.
  - outputs: one-hot grant, binary index, any.
  - purely combinational.
- Storage: lix_reg #(W) instance for o_z.
- Top level: full flag, ptr update, handshake glue.

Test Plan:
- Reset mid-transfer: load 32'hA5A5_0001 from requester 2, assert rst_i between edges -> o_vld=0, o_z=0, o_id=0 immediately; after release, first grant goes to the lowest valid index ≥ 0.
- All four valid continuously, i_rdy=1 -> grants cycle 0,1,2,3,0,…; o_id follows one cycle later; o_vld stays high; one word per cycle.
- i_vld=4'b1010, ptr=0 -> grant 1, then 3, then 1; requesters 0 and 2 are never granted.
- Backpressure: o_vld=1, i_rdy=0 for 5 cycles with i_vld=4'b1111 -> o_rdy=0, o_z stable, ptr unchanged; when i_rdy=1, the next grant goes to the stored ptr.
- Drain with no request: full, i_rdy=1, i_vld=0 -> o_vld falls next cycle and o_z keeps its last value.
- N=1, W=8: i_vld=1, i_x=8'h3C, i_rdy toggling -> o_rdy[0] = ~full | i_rdy; o_z=8'h3C after 1 cycle; no word is lost or duplicated.
